// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM encoding and default bus geometry.
package apb_pkg;

  localparam int unsigned APB_AW      = 10;
  localparam int unsigned APB_DW      = 32;
  localparam int unsigned APB_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating count of consecutive PREADY=0 ACCESS cycles; expired marks the
// last stall cycle allowed before the transfer is aborted.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt <= '0;
      end else if (en && (cnt != CW'(TIMEOUT))) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3 initiator: one valid/ready command becomes one
// SETUP/ACCESS transfer and one held response.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          busy,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  apb_state_t state;
  logic       expired;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Counter is held at zero outside ACCESS, so every transfer starts fresh.
  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr     (state != ACCESS),
    .en      ((state == ACCESS) && !PREADY),
    .expired (expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A completing PREADY takes priority over a timeout on the same edge.
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            state       <= RESP;
          end else if (expired) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
